// File: rtl/otp_cypher_core.sv
// One-time-pad style stream cipher: seeded 8-bit Fibonacci LFSR keystream
// (one byte per enabled cycle) feeding a registered per-byte XOR encryptor.

module otp_xor_lane (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] pt,
  input  logic [7:0] key,
  output logic [7:0] ct,
  output logic [7:0] key_q
);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ct    <= '0;
      key_q <= '0;
    end else begin
      ct    <= pt ^ key;
      key_q <= key;
    end
  end
endmodule

module otp_cypher_core #(
  parameter int MSG_SIZE = 136
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                en,
  input  logic [7:0]          seed,
  input  logic [MSG_SIZE-1:0] plaintext,
  output logic [MSG_SIZE-1:0] otp,
  output logic [MSG_SIZE-1:0] ciphertext,
  output logic [MSG_SIZE-1:0] key_used,
  output logic                valid
);
  localparam int NUM_LANES = MSG_SIZE / 8;

  typedef enum logic {LOAD, RUN} state_t;

  state_t              state, state_nxt;
  logic [7:0]          lfsr, lfsr_nxt, lfsr_adv, seed_eff, ks_byte;
  logic [MSG_SIZE-1:0] otp_nxt, otp_shifted;

  // Zero would lock the LFSR, so it is swapped for the first nonzero state.
  assign seed_eff = (seed == 8'h00) ? 8'h01 : seed;

  // Eight LFSR steps per cycle; after 8 shifts the register holds exactly
  // the feedback bits, so the keystream byte and next state coincide.
  always_comb begin
    logic [7:0] l;
    logic       fb;
    l       = lfsr;
    fb      = 1'b0;
    ks_byte = '0;
    for (int i = 0; i < 8; i++) begin
      fb             = l[7] ^ l[5] ^ l[4] ^ l[3];
      ks_byte[7-i]   = fb;
      l              = {l[6:0], fb};
    end
    lfsr_adv = l;
  end

  generate
    if (MSG_SIZE == 8) begin : g_shift_narrow
      assign otp_shifted = ks_byte;
    end else begin : g_shift_wide
      assign otp_shifted = {otp[MSG_SIZE-9:0], ks_byte};
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= LOAD;
      lfsr  <= 8'h01;
      otp   <= '0;
      valid <= 1'b0;
    end else begin
      state <= state_nxt;
      lfsr  <= lfsr_nxt;
      otp   <= otp_nxt;
      valid <= (state == RUN);
    end
  end

  always_comb begin
    state_nxt = state;
    lfsr_nxt  = lfsr;
    otp_nxt   = otp;
    case (state)
      LOAD: begin
        state_nxt = RUN;
        lfsr_nxt  = seed_eff;
        otp_nxt   = {NUM_LANES{seed_eff}};
      end
      RUN: begin
        if (en) begin
          lfsr_nxt = lfsr_adv;
          otp_nxt  = otp_shifted;
        end
      end
      default: state_nxt = LOAD;
    endcase
  end

  // Encryptor runs every edge regardless of en.
  generate
    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
      otp_xor_lane u_lane (
        .clk   (clk),
        .reset (reset),
        .pt    (plaintext[g*8 +: 8]),
        .key   (otp[g*8 +: 8]),
        .ct    (ciphertext[g*8 +: 8]),
        .key_q (key_used[g*8 +: 8])
      );
    end
  endgenerate
endmodule

// File: tb/tb_otp_cypher_core.sv
// Directed plus randomized bench for otp_cypher_core against a keystream model.

module tb_otp_cypher_core;
  localparam int W = 136;

  logic         clk = 1'b0;
  logic         reset, en;
  logic [7:0]   seed;
  logic [W-1:0] plaintext, otp, ciphertext, key_used;
  logic         valid;

  int npass = 0;
  int ntot  = 0;

  otp_cypher_core #(.MSG_SIZE(W)) dut (
    .clk(clk), .reset(reset), .en(en), .seed(seed), .plaintext(plaintext),
    .otp(otp), .ciphertext(ciphertext), .key_used(key_used), .valid(valid)
  );

  always #5 clk = ~clk;

  // reference model
  bit           m_loaded;
  logic [7:0]   m_lfsr;
  logic [W-1:0] m_otp, m_ct, m_key;
  logic         m_valid;

  task automatic model_reset();
    m_loaded = 0; m_lfsr = 8'h01; m_otp = '0; m_ct = '0; m_key = '0; m_valid = 0;
  endtask

  task automatic model_edge();
    logic [7:0] b;
    logic       fb;
    m_ct    = plaintext ^ m_otp;
    m_key   = m_otp;
    m_valid = m_loaded;
    if (!m_loaded) begin
      m_lfsr   = (seed == 0) ? 8'h01 : seed;
      m_otp    = {17{m_lfsr}};
      m_loaded = 1;
    end else if (en) begin
      b = '0;
      for (int i = 0; i < 8; i++) begin
        fb     = m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3];
        m_lfsr = {m_lfsr[6:0], fb};
        b      = {b[6:0], fb};
      end
      m_otp = (m_otp << 8) | {{(W-8){1'b0}}, b};
    end
  endtask

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".otp"}, otp, m_otp);
    chk({tag, ".ct"},  ciphertext, m_ct);
    chk({tag, ".key"}, key_used, m_key);
    chk({tag, ".valid"}, {{(W-1){1'b0}}, valid}, {{(W-1){1'b0}}, m_valid});
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic rand_pt();
    for (int i = 0; i < 17; i++) plaintext[i*8 +: 8] = 8'($urandom);
  endtask

  logic [W-1:0] saved_otp;
  int           first_ret;

  initial begin
    reset = 1'b1; en = 1'b0; seed = 8'h33; plaintext = '0;
    model_reset();
    #2;
    chk_all("reset");

    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("load33.otp", otp, {17{8'h33}});
    chk_all("load33");

    en = 1'b1;
    tick();
    chk("run1.otp", otp, {{16{8'h33}}, 8'h51});
    chk("run1.valid", {{(W-1){1'b0}}, valid}, {{(W-1){1'b0}}, 1'b1});
    chk_all("run1");

    plaintext = "Pearl Jam - Black";
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_all("pj");
      chk("pj.decrypt", ciphertext ^ key_used, plaintext);
      chk("pj.differs", {{(W-1){1'b0}}, (ciphertext !== plaintext)}, {{(W-1){1'b0}}, 1'b1});
    end

    en = 1'b0;
    saved_otp = otp;
    tick();
    saved_otp = otp;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("hold.otp", otp, saved_otp);
      chk_all("hold");
    end

    // random en/plaintext/seed in RUN; seed must be ignored
    for (int k = 0; k < 40; k++) begin
      en   = 1'($urandom);
      seed = 8'($urandom);
      rand_pt();
      tick();
      chk_all("rand");
    end

    // asynchronous reset mid-cycle
    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all("async_rst");

    seed = 8'h00; en = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("load00.otp", otp, {17{8'h01}});
    chk_all("load00");

    first_ret = -1;
    for (int k = 1; k <= 255; k++) begin
      tick();
      chk_all("period");
      chk("period.nonzero", {{(W-1){1'b0}}, (otp[7:0] != 8'h00)}, {{(W-1){1'b0}}, 1'b1});
      if (otp[7:0] == 8'h01 && first_ret < 0) first_ret = k;
    end
    chk("period.len", W'(first_ret), W'(255));

    #3;
    reset = 1'b1;
    model_reset();
    #1;
    chk_all("rst2");
    seed = 8'hA5;
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("loadA5.otp", otp, {17{8'hA5}});
    chk_all("loadA5");
    tick();
    chk_all("runA5");

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
